pll_lock_supervisor: RTL and testbench

- Drives the reset input of the clock-generation PLL and consumes its `locked` output.
- Sequences PLL reset, then waits for lock with a timeout and bounded retries.
- Requires lock to be stable before releasing the system reset, and restarts the whole sequence if lock is lost.
- Runs on the 50 MHz board reference clock, which exists before the PLL does. Generated-clock domains resynchronise `sys_rst_n` locally.

---
 rtl/pll_sup_pkg.sv | 23 ++
 rtl/sync_bit.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 116 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// PLL lock supervisor shared definitions.
// Sequencer state encoding and counter sizing helper.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    // Width of a counter that must reach (largest cycle count - 1).
    function automatic int cnt_width(int a, int b, int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Synchronous active-low reset clears every stage.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the async input through the flop chain.
    always_ff @(posedge clk) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: reset pulse, lock wait with retries,
// stability qualification and system reset release.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 2500000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       lock_ok,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MX = 4'(MAX_RETRY);
    localparam logic [3:0]    RETRY_LS = 4'(MAX_RETRY - 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [3:0]      retry_nx;
    logic [7:0]      loss_nx;
    logic            locked_s;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (refclk),
        .rst_n(rst_n),
        .d    (pll_locked),
        .q    (locked_s)
    );

    // State, shared counter and event counters.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state     <= PLL_RST;
            cnt       <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            retry_cnt <= retry_nx;
            loss_cnt  <= loss_nx;
        end
    end

    // Next-state logic; relock_req overrides every other transition.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        retry_nx = retry_cnt;
        loss_nx  = loss_cnt;
        if (relock_req) begin
            state_nx = PLL_RST;
            retry_nx = '0;
        end else begin
            unique case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST) state_nx = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nx = STABLE;
                    end else if (cnt == TO_LAST) begin
                        if (retry_cnt == RETRY_LS) begin
                            state_nx = FAIL;
                            retry_nx = RETRY_MX;
                        end else begin
                            state_nx = PLL_RST;
                            retry_nx = retry_cnt + 4'd1;
                        end
                    end
                end
                STABLE: begin
                    if (!locked_s)           state_nx = WAIT_LOCK;
                    else if (cnt == ST_LAST) state_nx = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        state_nx = PLL_RST;
                        if (loss_cnt != 8'hFF) loss_nx = loss_cnt + 8'd1;
                    end
                end
                FAIL: begin
                    state_nx = FAIL;
                end
                default: begin
                    state_nx = PLL_RST;
                end
            endcase
        end
        if (relock_req || state_nx != state ||
            state == RUN || state == FAIL)
            cnt_nx = '0;
    end

    assign pll_rst   = (state == PLL_RST);
    assign sys_rst_n = (state == RUN);
    assign lock_ok   = (state == RUN);
    assign fail      = (state == FAIL);

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a vector table
// plus a hand-written mid-sequence reset scenario.
module tb_pll_lock_supervisor;

    logic       refclk     = 1'b0;
    logic       rst_n      = 1'b0;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_ok;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          ncyc;
        logic        locked;
        logic        relock;
        logic [15:0] exp;
    } vec_t;

    vec_t vq[$];

    pll_lock_supervisor #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .STABLE_CYCLES(8),
        .MAX_RETRY    (3),
        .SYNC_STAGES  (2)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .lock_ok   (lock_ok),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #10 refclk = ~refclk;

    function automatic logic [15:0] ex(bit pr, bit sr, bit lk, bit fl,
                                       logic [3:0] rt, logic [7:0] ls);
        return {pr, sr, lk, fl, rt, ls};
    endfunction

    function automatic logic [15:0] obs();
        return {pll_rst, sys_rst_n, lock_ok, fail, retry_cnt, loss_cnt};
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: {pll_rst,sys_rst_n,lock_ok,fail,retry,loss} got=%h exp=%h",
                     nm, got, exp);
        end
    endtask

    task automatic add(int n, bit lk, bit rq, logic [15:0] e);
        vec_t v;
        v.ncyc   = n;
        v.locked = lk;
        v.relock = rq;
        v.exp    = e;
        vq.push_back(v);
    endtask

    initial begin
        // nominal lock
        add(3,   0, 0, ex(1, 0, 0, 0, 0, 0));
        add(1,   0, 0, ex(0, 0, 0, 0, 0, 0));
        add(10,  0, 0, ex(0, 0, 0, 0, 0, 0));
        add(10,  1, 0, ex(0, 0, 0, 0, 0, 0));
        add(1,   1, 0, ex(0, 1, 1, 0, 0, 0));
        add(5,   1, 0, ex(0, 1, 1, 0, 0, 0));
        // loss in RUN and relock
        add(2,   0, 0, ex(0, 1, 1, 0, 0, 0));
        add(1,   0, 0, ex(1, 0, 0, 0, 0, 1));
        add(3,   1, 0, ex(1, 0, 0, 0, 0, 1));
        add(1,   1, 0, ex(0, 0, 0, 0, 0, 1));
        add(8,   1, 0, ex(0, 0, 0, 0, 0, 1));
        add(1,   1, 0, ex(0, 1, 1, 0, 0, 1));
        // relock_req coincident with locked_s fall in RUN
        add(2,   0, 0, ex(0, 1, 1, 0, 0, 1));
        add(1,   0, 1, ex(1, 0, 0, 0, 0, 1));
        // timeouts, retries, FAIL
        add(3,   0, 0, ex(1, 0, 0, 0, 0, 1));
        add(1,   0, 0, ex(0, 0, 0, 0, 0, 1));
        add(99,  0, 0, ex(0, 0, 0, 0, 0, 1));
        add(1,   0, 0, ex(1, 0, 0, 0, 1, 1));
        add(3,   0, 0, ex(1, 0, 0, 0, 1, 1));
        add(1,   0, 0, ex(0, 0, 0, 0, 1, 1));
        add(99,  0, 0, ex(0, 0, 0, 0, 1, 1));
        add(1,   0, 0, ex(1, 0, 0, 0, 2, 1));
        add(4,   0, 0, ex(0, 0, 0, 0, 2, 1));
        add(99,  0, 0, ex(0, 0, 0, 0, 2, 1));
        add(1,   0, 0, ex(0, 0, 0, 1, 3, 1));
        add(300, 0, 0, ex(0, 0, 0, 1, 3, 1));
        // relock_req out of FAIL
        add(1,   0, 1, ex(1, 0, 0, 0, 0, 1));
        // one-cycle glitch at STABLE count 5
        add(3,   1, 0, ex(1, 0, 0, 0, 0, 1));
        add(1,   1, 0, ex(0, 0, 0, 0, 0, 1));
        add(1,   1, 0, ex(0, 0, 0, 0, 0, 1));
        add(3,   1, 0, ex(0, 0, 0, 0, 0, 1));
        add(1,   0, 0, ex(0, 0, 0, 0, 0, 1));
        add(1,   1, 0, ex(0, 0, 0, 0, 0, 1));
        add(1,   1, 0, ex(0, 0, 0, 0, 0, 1));
        add(8,   1, 0, ex(0, 0, 0, 0, 0, 1));
        add(1,   1, 0, ex(0, 1, 1, 0, 0, 1));

        rst_n = 1'b0;
        step(3);
        chk("reset", obs(), ex(1, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            pll_locked = vq[i].locked;
            relock_req = vq[i].relock;
            step(vq[i].ncyc);
            relock_req = 1'b0;
            chk($sformatf("vec%0d", i), obs(), vq[i].exp);
        end

        // reset asserted for one cycle during STABLE
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        chk("relock_run", obs(), ex(1, 0, 0, 0, 0, 1));
        step(4);
        chk("relock_wait", obs(), ex(0, 0, 0, 0, 0, 1));
        step(2);
        chk("in_stable", obs(), ex(0, 0, 0, 0, 0, 1));
        rst_n = 1'b0;
        step(1);
        chk("mid_reset", obs(), ex(1, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        step(3);
        chk("rst_pulse_hi", obs(), ex(1, 0, 0, 0, 0, 0));
        step(1);
        chk("rst_pulse_lo", obs(), ex(0, 0, 0, 0, 0, 0));
        step(8);
        chk("restable", obs(), ex(0, 0, 0, 0, 0, 0));
        step(1);
        chk("rerun", obs(), ex(0, 1, 1, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
